uc_secuenciador: RTL and testbench

Sequencing control unit for the 8-bit microcontroller datapath (10-bit PC, 16-bit instructions, 6-bit Opcode, zero flag). Decodes Opcode and z into the datapath control lines s_inc, s_inm, we3, wez, Op and a PC enable. Adds run/halt/single-step sequencing, a sticky illegal-opcode flag and an executed-instruction counter. Sits beside the datapath; the datapath PC register loads only when pc_en=1.

---
 rtl/uc_secuenciador.sv | 129 ++++++++++++
 tb/tb_uc_secuenciador.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uc_secuenciador.sv
// Sequencing control unit for the 8-bit microcontroller datapath.
// Ports: clk, reset (async low), Opcode, z, start, step_mode, step
//   -> s_inc, s_inm, we3, wez, Op, pc_en, running, halted,
//      illegal, instr_count.
module uc_secuenciador #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             running,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    STEP_WAIT,
    HALTED
  } state_t;

  localparam logic [5:0] OP_J   = 6'b110000;
  localparam logic [5:0] OP_JZ  = 6'b110001;
  localparam logic [5:0] OP_JNZ = 6'b110010;
  localparam logic [5:0] OP_NOP = 6'b111110;
  localparam logic [5:0] OP_HLT = 6'b111111;

  state_t           state_q, state_d;
  logic             step_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic exec;
  logic is_halt;
  logic is_bad;
  logic step_edge;

  assign exec      = (state_q == EXEC);
  assign step_edge = step & ~step_q;

  always_comb begin
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    Op      = 3'b000;
    pc_en   = 1'b0;
    is_halt = 1'b0;
    is_bad  = 1'b0;
    if (exec) begin
      pc_en = 1'b1;
      unique case (1'b1)
        ~Opcode[5]: begin
          Op  = Opcode[4:2];
          we3 = 1'b1;
          wez = 1'b1;
        end
        (Opcode[5:2] == 4'b1000): begin
          s_inm = 1'b1;
          we3   = 1'b1;
        end
        (Opcode == OP_J):   s_inc = 1'b0;
        (Opcode == OP_JZ):  s_inc = ~z;
        (Opcode == OP_JNZ): s_inc = z;
        (Opcode == OP_NOP): s_inc = 1'b1;
        (Opcode == OP_HLT): is_halt = 1'b1;
        default:            is_bad = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q | is_bad;
    cnt_d     = cnt_q;
    if (exec && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
    unique case (state_q)
      IDLE, HALTED: begin
        if (start)
          state_d = step_mode ? STEP_WAIT : EXEC;
      end
      EXEC: begin
        if (is_halt)
          state_d = HALTED;
        else if (step_mode)
          state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        // edges seen in other states are not remembered
        if (!step_mode || step_edge)
          state_d = EXEC;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign running     = (state_q == EXEC) || (state_q == STEP_WAIT);
  assign halted      = (state_q == HALTED);
  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_uc_secuenciador.sv
// Testbench for uc_secuenciador: decode table plus
// halt, step, illegal, reset and saturation sequences.
module tb_uc_secuenciador;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        z, start, step_mode, step;
  logic        s_inc, s_inm, we3, wez, pc_en;
  logic        running, halted, illegal;
  logic [2:0]  Op;
  logic [15:0] cnt;

  logic        t_inc, t_inm, t_we3, t_wez, t_pc;
  logic        t_run, t_hlt, t_ill;
  logic [2:0]  t_op;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;
  int execs;

  always #5 clk = ~clk;

  uc_secuenciador #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .start(start), .step_mode(step_mode), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .Op(Op), .pc_en(pc_en), .running(running),
    .halted(halted), .illegal(illegal), .instr_count(cnt)
  );

  uc_secuenciador #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z),
    .start(start), .step_mode(step_mode), .step(step),
    .s_inc(t_inc), .s_inm(t_inm), .we3(t_we3), .wez(t_wez),
    .Op(t_op), .pc_en(t_pc), .running(t_run),
    .halted(t_hlt), .illegal(t_ill), .instr_count(cnt2)
  );

  typedef struct {
    logic [5:0] opc;
    logic       z;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".pc_en"}, 32'(pc_en), 32'd0);
    chk({nm, ".we3"},   32'(we3),   32'd0);
    chk({nm, ".wez"},   32'(wez),   32'd0);
    chk({nm, ".s_inc"}, 32'(s_inc), 32'd1);
    chk({nm, ".s_inm"}, 32'(s_inm), 32'd0);
    chk({nm, ".Op"},    32'(Op),    32'd0);
  endtask

  initial begin
    vt[0]  = '{6'b000100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001};
    vt[1]  = '{6'b100000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
    vt[2]  = '{6'b110000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    vt[3]  = '{6'b011100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111};
    vt[4]  = '{6'b001011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010};
    vt[5]  = '{6'b100011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
    vt[6]  = '{6'b110001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    vt[7]  = '{6'b110001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
    vt[8]  = '{6'b110010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    vt[9]  = '{6'b110010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};
    vt[10] = '{6'b111110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};

    reset = 1'b0;
    Opcode = 6'b000100;
    z = 1'b0;
    start = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    repeat (2) tick();

    chk_idle("rst");
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.halted",  32'(halted),  32'd0);
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.count",   32'(cnt),     32'd0);

    reset = 1'b1;
    tick();
    chk_idle("idle");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.running", 32'(running), 32'd1);

    for (int i = 0; i < 11; i++) begin
      Opcode = vt[i].opc;
      z = vt[i].z;
      #1;
      chk($sformatf("v%0d.pc_en", i), 32'(pc_en), 32'd1);
      chk($sformatf("v%0d.s_inc", i), 32'(s_inc), 32'(vt[i].s_inc));
      chk($sformatf("v%0d.s_inm", i), 32'(s_inm), 32'(vt[i].s_inm));
      chk($sformatf("v%0d.we3", i),   32'(we3),   32'(vt[i].we3));
      chk($sformatf("v%0d.wez", i),   32'(wez),   32'(vt[i].wez));
      chk($sformatf("v%0d.Op", i),    32'(Op),    32'(vt[i].op));
      tick();
      if (i == 2) chk("prog.count", 32'(cnt), 32'd3);
      if (i == 1) chk("sat.count2", 32'(cnt2), 32'd2);
    end
    chk("tbl.count",   32'(cnt),     32'd11);
    chk("tbl.illegal", 32'(illegal), 32'd0);
    chk("sat.count",   32'(cnt2),    32'd3);

    Opcode = 6'b111111;
    #1;
    chk("hlt.pc_en", 32'(pc_en), 32'd1);
    chk("hlt.s_inc", 32'(s_inc), 32'd1);
    chk("hlt.we3",   32'(we3),   32'd0);
    tick();
    chk("hlt.halted",  32'(halted),  32'd1);
    chk("hlt.running", 32'(running), 32'd0);
    chk("hlt.count",   32'(cnt),     32'd12);
    chk_idle("hlt");
    Opcode = 6'b000100;
    tick();
    chk("hlt.stay",   32'(halted), 32'd1);
    chk("hlt.count2", 32'(cnt),    32'd12);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart.running", 32'(running), 32'd1);
    chk("restart.we3",     32'(we3),     32'd1);
    chk("restart.pc_en",   32'(pc_en),   32'd1);
    tick();
    chk("restart.count", 32'(cnt), 32'd13);

    Opcode = 6'b101000;
    #1;
    chk("ill.we3",   32'(we3),     32'd0);
    chk("ill.wez",   32'(wez),     32'd0);
    chk("ill.s_inc", 32'(s_inc),   32'd1);
    chk("ill.pc_en", 32'(pc_en),   32'd1);
    chk("ill.pre",   32'(illegal), 32'd0);
    tick();
    chk("ill.set",   32'(illegal), 32'd1);
    chk("ill.count", 32'(cnt),     32'd14);
    Opcode = 6'b000100;
    repeat (2) tick();
    chk("ill.sticky",  32'(illegal), 32'd1);
    chk("ill.running", 32'(running), 32'd1);

    #2;
    reset = 1'b0;
    #1;
    chk_idle("async");
    chk("async.running", 32'(running), 32'd0);
    chk("async.count",   32'(cnt),     32'd0);
    chk("async.illegal", 32'(illegal), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("postrst.running", 32'(running), 32'd0);

    step_mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sw.running", 32'(running), 32'd1);
    chk("sw.pc_en",   32'(pc_en),   32'd0);
    execs = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      repeat (4) begin
        tick();
        if (pc_en) execs++;
      end
      step = 1'b0;
      repeat (4) begin
        tick();
        if (pc_en) execs++;
      end
    end
    chk("step.execs", 32'(execs), 32'd3);
    chk("step.count", 32'(cnt),   32'd3);
    chk("step.wait",  32'(pc_en), 32'd0);
    step_mode = 1'b0;
    tick();
    chk("resume.pc_en1", 32'(pc_en), 32'd1);
    tick();
    chk("resume.pc_en2", 32'(pc_en), 32'd1);
    chk("resume.count",  32'(cnt),   32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
